axi4_lite_master: RTL and testbench

AXI4_LITE_MASTER -- requirements
Module: axi4_lite_master

---
 rtl/axi4_lite_master.sv | 193 +++++++++++++++++++
 tb/tb_axi4_lite_master.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi4_lite_master.sv
// axi4_lite_master: single-outstanding AXI4-Lite master driven by a
// simple start/done command port.
//
// Ports:
//   ACLK, ARESETn            clock, async active-low reset
//   cmd_start/write/addr/wdata  command request (taken only when ready)
//   cmd_ready                 high while idle
//   cmd_done                  one-cycle completion pulse
//   cmd_rdata, cmd_resp       last read data / last response
//   AW*, W*, B*, AR*, R*      AXI4-Lite master channels
module axi4_lite_master #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 32
) (
  input  logic              ACLK,
  input  logic              ARESETn,
  input  logic              cmd_start,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              cmd_ready,
  output logic              cmd_done,
  output logic [DATA_W-1:0] cmd_rdata,
  output logic [1:0]        cmd_resp,
  output logic [ADDR_W-1:0] AWADDR,
  output logic              AWVALID,
  input  logic              AWREADY,
  output logic [DATA_W-1:0] WDATA,
  output logic              WVALID,
  input  logic              WREADY,
  input  logic [1:0]        BRESP,
  input  logic              BVALID,
  output logic              BREADY,
  output logic [ADDR_W-1:0] ARADDR,
  output logic              ARVALID,
  input  logic              ARREADY,
  input  logic [DATA_W-1:0] RDATA,
  input  logic              RVALID,
  output logic              RREADY,
  input  logic [1:0]        RRESP
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR,
    S_WR_RESP,
    S_RD_ADDR,
    S_RD_DATA
  } state_t;

  state_t r_state;

  logic r_aw_done;
  logic r_w_done;

  logic r_awvalid;
  logic r_wvalid;
  logic r_bready;
  logic r_arvalid;
  logic r_rready;
  logic r_cmd_ready;
  logic r_cmd_done;

  logic [ADDR_W-1:0] r_awaddr;
  logic [DATA_W-1:0] r_wdata;
  logic [ADDR_W-1:0] r_araddr;
  logic [DATA_W-1:0] r_rdata;
  logic [1:0]        r_resp;

  logic w_aw_hs;
  logic w_w_hs;
  logic w_b_hs;
  logic w_ar_hs;
  logic w_r_hs;
  logic w_aw_all;
  logic w_w_all;

  assign w_aw_hs = r_awvalid & AWREADY;
  assign w_w_hs  = r_wvalid  & WREADY;
  assign w_b_hs  = r_bready  & BVALID;
  assign w_ar_hs = r_arvalid & ARREADY;
  assign w_r_hs  = r_rready  & RVALID;

  // A channel counts as done if it finished earlier
  // or is finishing on this edge.
  assign w_aw_all = r_aw_done | w_aw_hs;
  assign w_w_all  = r_w_done  | w_w_hs;

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      r_state     <= S_IDLE;
      r_aw_done   <= 1'b0;
      r_w_done    <= 1'b0;
      r_awvalid   <= 1'b0;
      r_wvalid    <= 1'b0;
      r_bready    <= 1'b0;
      r_arvalid   <= 1'b0;
      r_rready    <= 1'b0;
      r_cmd_ready <= 1'b1;
      r_cmd_done  <= 1'b0;
      r_awaddr    <= '0;
      r_wdata     <= '0;
      r_araddr    <= '0;
      r_rdata     <= '0;
      r_resp      <= '0;
    end else begin
      r_cmd_done <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (cmd_start) begin
            r_cmd_ready <= 1'b0;
            if (cmd_write) begin
              r_awaddr  <= cmd_addr;
              r_wdata   <= cmd_wdata;
              r_awvalid <= 1'b1;
              r_wvalid  <= 1'b1;
              r_aw_done <= 1'b0;
              r_w_done  <= 1'b0;
              r_state   <= S_WR;
            end else begin
              r_araddr  <= cmd_addr;
              r_arvalid <= 1'b1;
              r_state   <= S_RD_ADDR;
            end
          end
        end
        S_WR: begin
          if (w_aw_hs) begin
            r_awvalid <= 1'b0;
            r_aw_done <= 1'b1;
          end
          if (w_w_hs) begin
            r_wvalid <= 1'b0;
            r_w_done <= 1'b1;
          end
          if (w_aw_all && w_w_all) begin
            r_bready <= 1'b1;
            r_state  <= S_WR_RESP;
          end
        end
        S_WR_RESP: begin
          if (w_b_hs) begin
            r_resp      <= BRESP;
            r_cmd_done  <= 1'b1;
            r_bready    <= 1'b0;
            r_cmd_ready <= 1'b1;
            r_state     <= S_IDLE;
          end
        end
        S_RD_ADDR: begin
          if (w_ar_hs) begin
            r_arvalid <= 1'b0;
            r_rready  <= 1'b1;
            r_state   <= S_RD_DATA;
          end
        end
        S_RD_DATA: begin
          if (w_r_hs) begin
            r_rdata     <= RDATA;
            r_resp      <= RRESP;
            r_cmd_done  <= 1'b1;
            r_rready    <= 1'b0;
            r_cmd_ready <= 1'b1;
            r_state     <= S_IDLE;
          end
        end
        default: begin
          r_awvalid   <= 1'b0;
          r_wvalid    <= 1'b0;
          r_bready    <= 1'b0;
          r_arvalid   <= 1'b0;
          r_rready    <= 1'b0;
          r_cmd_ready <= 1'b1;
          r_state     <= S_IDLE;
        end
      endcase
    end
  end

  assign cmd_ready = r_cmd_ready;
  assign cmd_done  = r_cmd_done;
  assign cmd_rdata = r_rdata;
  assign cmd_resp  = r_resp;
  assign AWADDR    = r_awaddr;
  assign AWVALID   = r_awvalid;
  assign WDATA     = r_wdata;
  assign WVALID    = r_wvalid;
  assign BREADY    = r_bready;
  assign ARADDR    = r_araddr;
  assign ARVALID   = r_arvalid;
  assign RREADY    = r_rready;

endmodule

// File: tb/tb_axi4_lite_master.sv
// tb_axi4_lite_master: directed + random transactions against a
// memory-backed slave with programmable wait states.
module tb_axi4_lite_master;

  logic        ACLK;
  logic        ARESETn;
  logic        cmd_start;
  logic        cmd_write;
  logic [3:0]  cmd_addr;
  logic [31:0] cmd_wdata;
  logic        cmd_ready;
  logic        cmd_done;
  logic [31:0] cmd_rdata;
  logic [1:0]  cmd_resp;
  logic [3:0]  AWADDR;
  logic        AWVALID;
  logic        AWREADY;
  logic [31:0] WDATA;
  logic        WVALID;
  logic        WREADY;
  logic [1:0]  BRESP;
  logic        BVALID;
  logic        BREADY;
  logic [3:0]  ARADDR;
  logic        ARVALID;
  logic        ARREADY;
  logic [31:0] RDATA;
  logic        RVALID;
  logic        RREADY;
  logic [1:0]  RRESP;

  axi4_lite_master #(.ADDR_W(4), .DATA_W(32)) dut (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .cmd_start(cmd_start), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .cmd_ready(cmd_ready), .cmd_done(cmd_done),
    .cmd_rdata(cmd_rdata), .cmd_resp(cmd_resp),
    .AWADDR(AWADDR), .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WVALID(WVALID), .WREADY(WREADY),
    .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .ARADDR(ARADDR), .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RDATA(RDATA), .RVALID(RVALID), .RREADY(RREADY),
    .RRESP(RRESP)
  );

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  // slave configuration
  int aw_dly, w_dly, b_dly, ar_dly, r_dly;
  logic [1:0] s_bresp, s_rresp;

  // slave state
  int aw_cnt, w_cnt, b_cnt, ar_cnt, r_cnt;
  logic [3:0]  s_awaddr, s_araddr;
  logic [31:0] s_wdata;
  logic [31:0] s_mem [16];

  assign AWREADY = AWVALID && (aw_cnt >= aw_dly);
  assign WREADY  = WVALID  && (w_cnt  >= w_dly);
  assign BVALID  = BREADY  && (b_cnt  >= b_dly);
  assign ARREADY = ARVALID && (ar_cnt >= ar_dly);
  assign RVALID  = RREADY  && (r_cnt  >= r_dly);
  assign BRESP   = s_bresp;
  assign RRESP   = s_rresp;
  assign RDATA   = s_mem[s_araddr];

  always @(posedge ACLK) begin
    aw_cnt <= (AWVALID && !AWREADY) ? aw_cnt + 1 : 0;
    w_cnt  <= (WVALID  && !WREADY)  ? w_cnt  + 1 : 0;
    b_cnt  <= (BREADY  && !BVALID)  ? b_cnt  + 1 : 0;
    ar_cnt <= (ARVALID && !ARREADY) ? ar_cnt + 1 : 0;
    r_cnt  <= (RREADY  && !RVALID)  ? r_cnt  + 1 : 0;
    if (AWVALID && AWREADY) s_awaddr <= AWADDR;
    if (WVALID && WREADY)   s_wdata  <= WDATA;
    if (ARVALID && ARREADY) s_araddr <= ARADDR;
    if (BVALID && BREADY && s_bresp == 2'b00)
      s_mem[s_awaddr] <= s_wdata;
  end

  // protocol monitors
  int awv_n, wv_n, arv_n, done_n;
  int ovl_n, unstab_n, acc_n;
  logic p_aw, p_w, p_ar;
  logic [3:0]  p_awaddr, p_araddr;
  logic [31:0] p_wdata;

  always @(negedge ACLK) begin
    if (AWVALID)  awv_n  <= awv_n + 1;
    if (WVALID)   wv_n   <= wv_n + 1;
    if (ARVALID)  arv_n  <= arv_n + 1;
    if (cmd_done) done_n <= done_n + 1;
  end

  always @(posedge ACLK) begin
    if (AWVALID && ARVALID) ovl_n <= ovl_n + 1;
    if (cmd_start && cmd_ready) acc_n <= acc_n + 1;
    if ((p_aw && (!AWVALID || AWADDR !== p_awaddr)) ||
        (p_w  && (!WVALID  || WDATA  !== p_wdata))  ||
        (p_ar && (!ARVALID || ARADDR !== p_araddr)))
      unstab_n <= unstab_n + 1;
    p_aw     <= AWVALID && !AWREADY;
    p_w      <= WVALID  && !WREADY;
    p_ar     <= ARVALID && !ARREADY;
    p_awaddr <= AWADDR;
    p_wdata  <= WDATA;
    p_araddr <= ARADDR;
  end

  // reference model
  logic [31:0] ref_mem [16];
  logic [31:0] exp_rdata;
  logic [1:0]  exp_resp;

  int n_chk;
  int n_fail;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_ctl"},
        64'({AWVALID, WVALID, BREADY, ARVALID, RREADY,
             cmd_done, cmd_ready}),
        64'(7'b0000001));
    chk({tag, "_awaddr"}, 64'(AWADDR), 64'(0));
    chk({tag, "_wdata"},  64'(WDATA), 64'(0));
    chk({tag, "_araddr"}, 64'(ARADDR), 64'(0));
    chk({tag, "_rdata"},  64'(cmd_rdata), 64'(0));
    chk({tag, "_resp"},   64'(cmd_resp), 64'(0));
  endtask

  function automatic int exp_latency(input logic wr);
    int m;
    m = (aw_dly > w_dly) ? aw_dly : w_dly;
    return wr ? 3 + m + b_dly : 3 + ar_dly + r_dly;
  endfunction

  function automatic void model_done(input logic wr,
                                     input logic [3:0] a,
                                     input logic [31:0] d);
    if (wr) begin
      exp_resp = s_bresp;
      if (s_bresp == 2'b00) ref_mem[a] = d;
    end else begin
      exp_resp  = s_rresp;
      exp_rdata = ref_mem[a];
    end
  endfunction

  task automatic run(input logic wr,
                     input logic [3:0] a,
                     input logic [31:0] d);
    int n, e_lat, awv0, wv0, arv0, dn0;
    logic got;
    @(negedge ACLK);
    chk("ready_before", 64'(cmd_ready), 64'(1));
    awv0 = awv_n; wv0 = wv_n; arv0 = arv_n; dn0 = done_n;
    e_lat = exp_latency(wr);
    cmd_start = 1'b1;
    cmd_write = wr;
    cmd_addr  = a;
    cmd_wdata = d;
    n = 0;
    got = 1'b0;
    while (!got && n < 200) begin
      @(negedge ACLK);
      n++;
      cmd_start = 1'b0;
      got = cmd_done;
    end
    model_done(wr, a, d);
    chk("done_seen", 64'(got), 64'(1));
    chk("latency", 64'(n), 64'(e_lat));
    chk("resp", 64'(cmd_resp), 64'(exp_resp));
    chk("rdata", 64'(cmd_rdata), 64'(exp_rdata));
    if (wr) begin
      chk("aw_addr", 64'(s_awaddr), 64'(a));
      chk("w_data", 64'(s_wdata), 64'(d));
      chk("aw_cycles", 64'(awv_n - awv0), 64'(1 + aw_dly));
      chk("w_cycles", 64'(wv_n - wv0), 64'(1 + w_dly));
    end else begin
      chk("ar_addr", 64'(s_araddr), 64'(a));
      chk("ar_cycles", 64'(arv_n - arv0), 64'(1 + ar_dly));
    end
    @(negedge ACLK);
    chk("done_pulse", 64'(cmd_done), 64'(0));
    chk("done_count", 64'(done_n - dn0), 64'(1));
  endtask

  task automatic zero_wait();
    aw_dly = 0; w_dly = 0; b_dly = 0;
    ar_dly = 0; r_dly = 0;
    s_bresp = 2'b00; s_rresp = 2'b00;
  endtask

  initial begin
    int n, dn0, acc0;
    logic [31:0] d;
    logic wr;
    n_chk = 0; n_fail = 0;
    awv_n = 0; wv_n = 0; arv_n = 0; done_n = 0;
    ovl_n = 0; unstab_n = 0; acc_n = 0;
    p_aw = 0; p_w = 0; p_ar = 0;
    aw_cnt = 0; w_cnt = 0; b_cnt = 0; ar_cnt = 0; r_cnt = 0;
    s_awaddr = 0; s_araddr = 0; s_wdata = 0;
    exp_rdata = 0; exp_resp = 0;
    zero_wait();
    ARESETn = 1'b0;
    cmd_start = 1'b0; cmd_write = 1'b0;
    cmd_addr = 0; cmd_wdata = 0;

    #12;
    chk_reset_vals("reset");
    @(negedge ACLK);
    ARESETn = 1'b1;

    // fill memory so every later read has a known value
    for (int i = 0; i < 16; i++) begin
      aw_dly = int'($urandom_range(0, 3));
      w_dly  = int'($urandom_range(0, 3));
      b_dly  = int'($urandom_range(0, 3));
      run(1'b1, 4'(i), $urandom);
    end
    zero_wait();

    // zero-wait write
    run(1'b1, 4'h8, 32'hDEADBEEF);

    // W before AW
    aw_dly = 4;
    run(1'b1, 4'h4, 32'hA5A5_0F0F);
    zero_wait();

    // delayed RVALID read
    run(1'b1, 4'hC, 32'h12345678);
    r_dly = 3;
    run(1'b0, 4'hC, 32'h0);
    chk("rd_value", 64'(cmd_rdata), 64'(32'h12345678));
    zero_wait();

    // error write response leaves read data alone
    s_bresp = 2'b10;
    run(1'b1, 4'hC, 32'hBAD0BAD0);
    chk("err_resp", 64'(cmd_resp), 64'(2'b10));
    chk("err_rdata", 64'(cmd_rdata), 64'(32'h12345678));
    s_bresp = 2'b00;
    run(1'b0, 4'hC, 32'h0);

    // back-to-back with cmd_start held high
    @(negedge ACLK);
    acc0 = acc_n;
    dn0 = done_n;
    d = $urandom;
    cmd_start = 1'b1; cmd_write = 1'b1;
    cmd_addr = 4'h5; cmd_wdata = d;
    n = 0;
    do begin
      @(negedge ACLK);
      n++;
    end while (!cmd_done && n < 200);
    model_done(1'b1, 4'h5, d);
    chk("b2b_wr_lat", 64'(n), 64'(3));
    chk("b2b_ready", 64'(cmd_ready), 64'(1));
    cmd_write = 1'b0;
    n = 0;
    do begin
      @(negedge ACLK);
      n++;
    end while (!cmd_done && n < 200);
    cmd_start = 1'b0;
    model_done(1'b0, 4'h5, 32'h0);
    chk("b2b_rd_lat", 64'(n), 64'(3));
    chk("b2b_rdata", 64'(cmd_rdata), 64'(exp_rdata));
    @(negedge ACLK);
    chk("b2b_accepts", 64'(acc_n - acc0), 64'(2));
    chk("b2b_dones", 64'(done_n - dn0), 64'(2));

    // reset while waiting for B
    b_dly = 6;
    @(negedge ACLK);
    cmd_start = 1'b1; cmd_write = 1'b1;
    cmd_addr = 4'h3; cmd_wdata = $urandom;
    @(negedge ACLK);
    cmd_start = 1'b0;
    n = 0;
    while (!BREADY && n < 50) begin
      @(negedge ACLK);
      n++;
    end
    chk("mid_bready", 64'(BREADY), 64'(1));
    dn0 = done_n;
    #2 ARESETn = 1'b0;
    #1 chk_reset_vals("mid_rst");
    @(negedge ACLK);
    chk_reset_vals("mid_hold");
    ARESETn = 1'b1;
    exp_rdata = 0;
    exp_resp = 0;
    @(negedge ACLK);
    @(negedge ACLK);
    chk("mid_no_done", 64'(done_n - dn0), 64'(0));
    zero_wait();
    run(1'b1, 4'h3, 32'h0BAD_CAFE);
    run(1'b0, 4'h3, 32'h0);

    // random mix
    for (int i = 0; i < 30; i++) begin
      aw_dly  = int'($urandom_range(0, 3));
      w_dly   = int'($urandom_range(0, 3));
      b_dly   = int'($urandom_range(0, 3));
      ar_dly  = int'($urandom_range(0, 3));
      r_dly   = int'($urandom_range(0, 3));
      s_bresp = 2'($urandom_range(0, 3));
      s_rresp = 2'($urandom_range(0, 3));
      wr = 1'($urandom_range(0, 1));
      run(wr, 4'($urandom_range(0, 15)), $urandom);
    end

    chk("aw_ar_overlap", 64'(ovl_n), 64'(0));
    chk("valid_stable", 64'(unstab_n), 64'(0));

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
